cv32e41s_rpm_responder: RTL and testbench

//  Region Protection Memory (RPM): responder for the PMP walker's implicit-read port (imp_*).

---
 rtl/cv32e41s_rpm_responder.sv | 158 +++++++++++++++
 tb/tb_cv32e41s_rpm_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41s_rpm_responder.sv
// Region Protection Memory responder: walker read port (imp_*), config read/write port (cfg_*),
// and a zero-fill scrub FSM that keeps every word invalid until software programs it.
`default_nettype none
module cv32e41s_rpm_responder #(
    parameter int unsigned RPM_WORDS = 2048,
    parameter int unsigned IMP_LAT   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        imp_req_i,
    input  logic [31:0] imp_addr_i,
    output logic        imp_rvalid_o,
    output logic [31:0] imp_rdata_o,
    output logic        imp_err_o,
    input  logic        cfg_req_i,
    input  logic        cfg_we_i,
    input  logic [31:0] cfg_addr_i,
    input  logic [3:0]  cfg_be_i,
    input  logic [31:0] cfg_wdata_i,
    output logic        cfg_rvalid_o,
    output logic [31:0] cfg_rdata_o,
    output logic        cfg_err_o,
    input  logic        lock_i,
    input  logic        scrub_i,
    output logic        ready_o
);

    localparam int unsigned AW = $clog2(4 * RPM_WORDS);
    localparam int unsigned IW = $clog2(RPM_WORDS);
    localparam logic [IW-1:0] LAST_IDX = IW'(RPM_WORDS - 1);

    typedef enum logic [0:0] {
        S_SCRUB = 1'b0,
        S_READY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [31:0]   mem [RPM_WORDS];

    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:AW] != '0);
    endfunction

    logic          rdy;
    logic          imp_ok;
    logic          cfg_ok;
    logic          cfg_wr_ok;
    logic [IW-1:0] imp_idx;
    logic [IW-1:0] cfg_idx;
    logic [31:0]   imp_word;

    assign rdy       = (state_q == S_READY);
    assign ready_o   = rst_n && rdy;
    assign imp_idx   = imp_addr_i[AW-1:2];
    assign cfg_idx   = cfg_addr_i[AW-1:2];
    assign imp_ok    = rdy && !addr_bad(imp_addr_i);
    assign cfg_ok    = rdy && !addr_bad(cfg_addr_i);
    assign cfg_wr_ok = rst_n && cfg_req_i && cfg_we_i && cfg_ok && !lock_i;
    assign imp_word  = mem[imp_idx];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_SCRUB: begin
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                if (scrub_i && !lock_i) begin
                    state_d = S_SCRUB;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = S_SCRUB;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_SCRUB;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Contents are deliberately unreset; the scrub pass is what clears them.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == S_SCRUB)) begin
            mem[idx_q] <= '0;
        end else if (cfg_wr_ok) begin
            for (int b = 0; b < 4; b++) begin
                if (cfg_be_i[b]) begin
                    mem[cfg_idx][8*b +: 8] <= cfg_wdata_i[8*b +: 8];
                end
            end
        end
    end

    logic        cfg_rvalid_q;
    logic [31:0] cfg_rdata_q;
    logic        cfg_err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cfg_rvalid_q <= 1'b0;
            cfg_rdata_q  <= '0;
            cfg_err_q    <= 1'b0;
        end else begin
            cfg_rvalid_q <= cfg_req_i;
            cfg_rdata_q  <= (cfg_req_i && !cfg_we_i && cfg_ok) ? mem[cfg_idx] : '0;
            cfg_err_q    <= cfg_req_i && (!cfg_ok || (cfg_we_i && lock_i));
        end
    end

    assign cfg_rvalid_o = cfg_rvalid_q;
    assign cfg_rdata_o  = cfg_rdata_q;
    assign cfg_err_o    = cfg_err_q;

    // Both latencies read the array before any same-edge write lands, giving read-first collisions.
    generate
        if (IMP_LAT == 0) begin : g_imp_comb
            assign imp_rvalid_o = rst_n && imp_req_i;
            assign imp_rdata_o  = (rst_n && imp_req_i && imp_ok) ? imp_word : '0;
            assign imp_err_o    = rst_n && imp_req_i && !imp_ok;
        end else begin : g_imp_reg
            logic        imp_rvalid_q;
            logic [31:0] imp_rdata_q;
            logic        imp_err_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    imp_rvalid_q <= 1'b0;
                    imp_rdata_q  <= '0;
                    imp_err_q    <= 1'b0;
                end else begin
                    imp_rvalid_q <= imp_req_i;
                    imp_rdata_q  <= (imp_req_i && imp_ok) ? imp_word : '0;
                    imp_err_q    <= imp_req_i && !imp_ok;
                end
            end

            assign imp_rvalid_o = imp_rvalid_q;
            assign imp_rdata_o  = imp_rdata_q;
            assign imp_err_o    = imp_err_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_cv32e41s_rpm_responder.sv
// Directed scoreboard bench: one combinational-walker and one registered-walker instance share stimulus.
`default_nettype none
module tb_cv32e41s_rpm_responder;

    logic        clk;
    logic        rst_n;
    logic        imp_req_i;
    logic [31:0] imp_addr_i;
    logic        cfg_req_i;
    logic        cfg_we_i;
    logic [31:0] cfg_addr_i;
    logic [3:0]  cfg_be_i;
    logic [31:0] cfg_wdata_i;
    logic        lock_i;
    logic        scrub_i;

    logic        rv0, er0, crv0, cer0, rdy0;
    logic [31:0] rd0, crd0;
    logic        rv1, er1, crv1, cer1, rdy1;
    logic [31:0] rd1, crd1;

    cv32e41s_rpm_responder #(.RPM_WORDS(16), .IMP_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .imp_req_i(imp_req_i), .imp_addr_i(imp_addr_i),
        .imp_rvalid_o(rv0), .imp_rdata_o(rd0), .imp_err_o(er0),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_be_i(cfg_be_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rvalid_o(crv0), .cfg_rdata_o(crd0), .cfg_err_o(cer0),
        .lock_i(lock_i), .scrub_i(scrub_i), .ready_o(rdy0)
    );

    cv32e41s_rpm_responder #(.RPM_WORDS(16), .IMP_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .imp_req_i(imp_req_i), .imp_addr_i(imp_addr_i),
        .imp_rvalid_o(rv1), .imp_rdata_o(rd1), .imp_err_o(er1),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_be_i(cfg_be_i), .cfg_wdata_i(cfg_wdata_i),
        .cfg_rvalid_o(crv1), .cfg_rdata_o(crd1), .cfg_err_o(cer1),
        .lock_i(lock_i), .scrub_i(scrub_i), .ready_o(rdy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } rsp_t;

    rsp_t        q_imp[$];
    rsp_t        q_cfg[$];
    int          checks   = 0;
    int          failures = 0;
    logic        e0_chk;
    logic [31:0] e0_d;
    logic        e0_e;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_imp(input logic [31:0] a, input logic [31:0] d, input logic e);
        imp_req_i  = 1'b1;
        imp_addr_i = a;
        e0_chk     = 1'b1;
        e0_d       = d;
        e0_e       = e;
        q_imp.push_back('{d: d, e: e});
    endtask

    task automatic set_cfg(input logic we, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic [31:0] d, input logic e);
        cfg_req_i   = 1'b1;
        cfg_we_i    = we;
        cfg_addr_i  = a;
        cfg_be_i    = be;
        cfg_wdata_i = wd;
        q_cfg.push_back('{d: d, e: e});
    endtask

    // Entered and left at a falling edge; walker-0 checked before the rising edge, registered ports after it.
    task automatic tick();
        rsp_t r;
        #4;
        if (e0_chk) begin
            chk("imp0_rvalid", rv0, 1);
            chk("imp0_rdata", rd0, e0_d);
            chk("imp0_err", er0, e0_e);
        end else begin
            chk("imp0_idle", rv0, 0);
        end
        @(posedge clk);
        #1;
        if (q_imp.size() > 0) begin
            r = q_imp.pop_front();
            chk("imp1_rvalid", rv1, 1);
            chk("imp1_rdata", rd1, r.d);
            chk("imp1_err", er1, r.e);
        end else begin
            chk("imp1_idle", rv1, 0);
        end
        if (q_cfg.size() > 0) begin
            r = q_cfg.pop_front();
            chk("cfg0_rvalid", crv0, 1);
            chk("cfg0_rdata", crd0, r.d);
            chk("cfg0_err", cer0, r.e);
            chk("cfg1_rvalid", crv1, 1);
            chk("cfg1_rdata", crd1, r.d);
            chk("cfg1_err", cer1, r.e);
        end else begin
            chk("cfg0_idle", crv0, 0);
            chk("cfg1_idle", crv1, 0);
        end
        @(negedge clk);
        imp_req_i = 1'b0;
        cfg_req_i = 1'b0;
        cfg_we_i  = 1'b0;
        cfg_be_i  = 4'h0;
        scrub_i   = 1'b0;
        e0_chk    = 1'b0;
    endtask

    task automatic chk_ready(input string tag, input logic exp);
        chk(tag, rdy0, exp);
        chk(tag, rdy1, exp);
    endtask

    task automatic scrub_window(input string tag);
        for (int i = 1; i <= 16; i++) begin
            if (i == 16) set_cfg(1'b1, 32'hC, 4'hF, 32'h0000_0001, 32'h0, 1'b1);
            tick();
            chk_ready(tag, (i == 16));
        end
    endtask

    task automatic read_all_zero();
        for (int w = 0; w < 16; w++) begin
            set_imp(32'(w * 4), 32'h0, 1'b0);
            set_cfg(1'b0, 32'(w * 4), 4'h0, 32'h0, 32'h0, 1'b0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; imp_req_i = 1'b0; imp_addr_i = '0;
        cfg_req_i = 1'b0; cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_be_i = '0; cfg_wdata_i = '0;
        lock_i = 1'b0; scrub_i = 1'b0; e0_chk = 1'b0; e0_d = '0; e0_e = 1'b0;
        @(negedge clk);
        tick();
        tick();
        chk_ready("rst_ready", 1'b0);

        // Initial scrub with a walker read and a config write landing inside it
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) set_imp(32'h8, 32'h0, 1'b1);
            if (i == 5) set_cfg(1'b1, 32'h8, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b1);
            if (i == 16) set_cfg(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1);
            tick();
            chk_ready("init_ready", (i == 16));
        end
        read_all_zero();

        // Program and read back
        set_cfg(1'b1, 32'h8, 4'hF, 32'h0004_0FFF, 32'h0, 1'b0); tick();
        set_imp(32'h8, 32'h0004_0FFF, 1'b0); tick();

        // Same-word collision: walker sees old data, later reads see new
        set_cfg(1'b1, 32'h4, 4'hF, 32'hAAAA_AAAA, 32'h0, 1'b0); tick();
        set_cfg(1'b1, 32'h4, 4'hF, 32'h5555_5555, 32'h0, 1'b0);
        set_imp(32'h4, 32'hAAAA_AAAA, 1'b0);
        tick();
        set_imp(32'h4, 32'h5555_5555, 1'b0);
        set_cfg(1'b0, 32'h4, 4'h0, 32'h0, 32'h5555_5555, 1'b0);
        tick();

        // Locked: write rejected, scrub ignored
        lock_i = 1'b1;
        set_cfg(1'b1, 32'h0, 4'hF, 32'h1234_5678, 32'h0, 1'b1); tick();
        scrub_i = 1'b1; tick();
        chk_ready("lock_scrub_ready", 1'b1);
        lock_i = 1'b0;
        set_cfg(1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 1'b0); tick();

        // Address errors and byte enables
        set_imp(32'h2, 32'h0, 1'b1); tick();
        set_imp(32'h40, 32'h0, 1'b1); tick();
        set_imp(32'h8000_0008, 32'h0, 1'b1); tick();
        set_cfg(1'b0, 32'h40, 4'h0, 32'h0, 32'h0, 1'b1); tick();
        set_cfg(1'b1, 32'h41, 4'hF, 32'h1, 32'h0, 1'b1); tick();
        set_cfg(1'b1, 32'hC, 4'b0100, 32'hFFFF_FFFF, 32'h0, 1'b0); tick();
        set_cfg(1'b0, 32'hC, 4'h0, 32'h0, 32'h00FF_0000, 1'b0); tick();
        set_cfg(1'b1, 32'h8, 4'h0, 32'hFFFF_FFFF, 32'h0, 1'b0); tick();
        set_cfg(1'b0, 32'h8, 4'h0, 32'h0, 32'h0004_0FFF, 1'b0); tick();

        // Unlocked re-scrub; a write on the closing edge is refused
        scrub_i = 1'b1; tick();
        chk_ready("rescrub_start", 1'b0);
        scrub_window("rescrub_ready");
        read_all_zero();

        // Reset mid-scrub (idx=7) with accesses in flight
        set_cfg(1'b1, 32'h14, 4'hF, 32'h1111_1111, 32'h0, 1'b0); tick();
        set_cfg(1'b0, 32'h14, 4'h0, 32'h0, 32'h1111_1111, 1'b0); tick();
        scrub_i = 1'b1; tick();
        for (int i = 0; i < 7; i++) tick();
        rst_n = 1'b0;
        imp_req_i = 1'b1; imp_addr_i = 32'h14;
        cfg_req_i = 1'b1; cfg_we_i = 1'b0; cfg_addr_i = 32'h14;
        tick();
        chk_ready("midrst_ready", 1'b0);
        rst_n = 1'b1;
        scrub_window("restart_ready");
        read_all_zero();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
